uart_rx: RTL and testbench

UART receiver: the receive-side counterpart of the system's UART transmitter. It oversamples the serial line `RX_IN` on the fast system clock and finds the start bit. It then recovers the LSB-first data byte, checks optional parity and the stop bit, and presents the byte on `P_DATA` with a one-cycle `Data_Valid` strobe. It sits between the RX pad, behind the RX clock-domain synchroniser, and the system data path. It shares `PAR_EN`/`PAR_TYP` configuration with the TX side.

---
 rtl/uart_rx.sv | 117 +++++++++++
 tb/tb_uart_rx.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// Oversampling UART receiver: 2-of-3 majority vote per bit, optional parity,
// and registered one-cycle result strobes once the stop bit has been judged.
module uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RX_IN,
  input  logic [PRESC_W-1:0]    Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Data_Valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  busy
);
  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state;
  logic [PRESC_W-1:0]    edge_cnt;
  logic [PRESC_W-1:0]    presc_lat;
  logic [BIT_W-1:0]      bit_cnt;
  logic                  par_en_lat;
  logic                  par_typ_lat;
  logic [2:0]            samples;
  logic [DATA_WIDTH-1:0] shadow;
  logic                  par_fail;

  logic [PRESC_W-1:0]    half;
  logic [PRESC_W-1:0]    last_edge;
  logic                  bit_end;
  logic                  bit_val;

  assign half      = presc_lat >> 1;
  assign last_edge = presc_lat - PRESC_W'(1);
  assign bit_end   = (edge_cnt == last_edge);
  assign bit_val   = (samples[0] & samples[1]) | (samples[0] & samples[2]) |
                     (samples[1] & samples[2]);

  // The IDLE cycle that sees RX_IN low is edge 0 of the start bit, so the
  // counter enters START already at 1 with the frame configuration frozen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      edge_cnt    <= '0;
      presc_lat   <= '0;
      bit_cnt     <= '0;
      par_en_lat  <= 1'b0;
      par_typ_lat <= 1'b0;
      samples     <= '1;
      shadow      <= '0;
      par_fail    <= 1'b0;
      P_DATA      <= '0;
      Data_Valid  <= 1'b0;
      par_err     <= 1'b0;
      stp_err     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      Data_Valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      if (state == IDLE) begin
        busy     <= ~RX_IN;
        edge_cnt <= '0;
        bit_cnt  <= '0;
        par_fail <= 1'b0;
        if (!RX_IN) begin
          state       <= START;
          edge_cnt    <= PRESC_W'(1);
          presc_lat   <= Prescale;
          par_en_lat  <= PAR_EN;
          par_typ_lat <= PAR_TYP;
        end
      end else begin
        busy     <= 1'b1;
        edge_cnt <= bit_end ? '0 : edge_cnt + PRESC_W'(1);
        if (edge_cnt == half - PRESC_W'(1)) samples[0] <= RX_IN;
        if (edge_cnt == half)               samples[1] <= RX_IN;
        if (edge_cnt == half + PRESC_W'(1)) samples[2] <= RX_IN;
        if (bit_end) begin
          unique case (state)
            START: state <= bit_val ? IDLE : DATA;
            DATA: begin
              shadow  <= {bit_val, shadow[DATA_WIDTH-1:1]};
              bit_cnt <= bit_cnt + BIT_W'(1);
              if (bit_cnt == BIT_W'(DATA_WIDTH - 1)) begin
                bit_cnt <= '0;
                state   <= par_en_lat ? PARITY : STOP;
              end
            end
            PARITY: begin
              if (bit_val != ((^shadow) ^ par_typ_lat)) par_fail <= 1'b1;
              state <= STOP;
            end
            STOP: begin
              state    <= IDLE;
              par_fail <= 1'b0;
              if (!par_fail && bit_val) begin
                P_DATA     <= shadow;
                Data_Valid <= 1'b1;
              end else begin
                par_err <= par_fail;
                stp_err <= ~bit_val;
              end
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: waveforms are built cycle by cycle and a
// frame-level decoder predicts busy, strobes and P_DATA for every cycle.
module tb_uart_rx;
  localparam int DW = 8;
  localparam int PW = 6;

  logic          TX_CLK_TB = 1'b0;
  logic          rst;
  logic          rx_in;
  logic [PW-1:0] prescale;
  logic          par_en;
  logic          par_typ;
  logic [DW-1:0] p_data;
  logic          data_valid;
  logic          par_err;
  logic          stp_err;
  logic          busy;

  int           checks = 0;
  int           failures = 0;
  int           strobe_cyc;
  logic         wave[$];
  logic [11:0]  expv[$];
  logic [7:0]   model_pdata = 8'h00;

  uart_rx #(.DATA_WIDTH(DW), .PRESC_W(PW)) dut (
    .clk(TX_CLK_TB), .rst(rst), .RX_IN(rx_in), .Prescale(prescale),
    .PAR_EN(par_en), .PAR_TYP(par_typ), .P_DATA(p_data),
    .Data_Valid(data_valid), .par_err(par_err), .stp_err(stp_err), .busy(busy)
  );

  always #5 TX_CLK_TB = ~TX_CLK_TB;

  task automatic checkOutput(input string tag, input int cyc,
                             input logic [11:0] obs, input logic [11:0] expd);
    checks++;
    assert (obs === expd) else begin
      failures++;
      $error("[TB] FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, expd);
    end
  endtask

  function automatic void pushLevel(input logic v, input int n);
    for (int i = 0; i < n; i++) wave.push_back(v);
  endfunction

  function automatic void pushFrame(input logic [7:0] d, input logic pbit,
                                    input logic stopv, input bit noisy);
    int         p = int'(prescale);
    logic [10:0] bits = '0;
    int         nb = 9;
    for (int b = 0; b < 8; b++) bits[1+b] = d[b];
    if (par_en) begin
      bits[nb] = pbit;
      nb++;
    end
    bits[nb] = stopv;
    nb++;
    for (int i = 0; i < nb; i++)
      for (int k = 0; k < p; k++)
        wave.push_back((noisy && k == p/2) ? ~bits[i] : bits[i]);
  endfunction

  function automatic logic sampleAt(input int i);
    return (i < wave.size()) ? wave[i] : 1'b1;
  endfunction

  // A bit reads as 1 when at least two of its three mid-bit samples are 1.
  function automatic logic vote(input int t, input int b, input int p);
    int base = t + b*p + p/2 - 1;
    int ones = 0;
    for (int j = 0; j < 3; j++) if (sampleAt(base + j)) ones++;
    return ones >= 2;
  endfunction

  function automatic void buildExpected();
    int         len = wave.size();
    int         p = int'(prescale);
    int         n = 10 + (par_en ? 1 : 0);
    int         t = 0;
    bit         bz[];
    bit         dv[];
    bit         pe[];
    bit         se[];
    logic [7:0] nd[];
    logic [7:0] hold = model_pdata;
    bz = new[len]; dv = new[len]; pe = new[len]; se = new[len]; nd = new[len];
    while (t < len) begin
      if (wave[t] === 1'b0) begin
        if (vote(t, 0, p)) begin
          for (int k = 1; k <= p; k++) if (t + k < len) bz[t+k] = 1'b1;
          t += p;
        end else begin
          logic [7:0] d;
          logic       pbad;
          logic       sbad;
          int         fin;
          for (int b = 0; b < 8; b++) d[b] = vote(t, 1 + b, p);
          pbad = par_en && (vote(t, 9, p) != ((^d) ^ par_typ));
          sbad = !vote(t, n - 1, p);
          fin  = t + n*p;
          for (int k = 1; k <= n*p; k++) if (t + k < len) bz[t+k] = 1'b1;
          if (fin < len) begin
            if (!pbad && !sbad) begin
              dv[fin] = 1'b1;
              nd[fin] = d;
            end else begin
              pe[fin] = pbad;
              se[fin] = sbad;
            end
          end
          t = fin;
        end
      end else begin
        t++;
      end
    end
    expv.delete();
    for (int c = 0; c < len; c++) begin
      if (dv[c]) hold = nd[c];
      expv.push_back({bz[c], dv[c], pe[c], se[c], hold});
    end
    model_pdata = hold;
  endfunction

  // Drives the prepared waveform, checking every cycle; stop_at > 0 aborts early.
  task automatic applyStimulus(input string tag, input int stop_at);
    int len = (stop_at > 0) ? stop_at : wave.size();
    strobe_cyc = -1;
    buildExpected();
    for (int c = 0; c < len; c++) begin
      @(negedge TX_CLK_TB);
      if (strobe_cyc < 0 && (data_valid || par_err || stp_err)) strobe_cyc = c;
      checkOutput(tag, c, {busy, data_valid, par_err, stp_err, p_data}, expv[c]);
      rx_in = wave[c];
    end
  endtask

  initial begin
    logic [7:0] d;
    logic       pbit;
    rst = 1'b1; rx_in = 1'b1; prescale = 6'd8; par_en = 1'b0; par_typ = 1'b0;
    repeat (2) @(negedge TX_CLK_TB);
    checkOutput("reset_state", 0, {busy, data_valid, par_err, stp_err, p_data}, 12'h000);
    rst = 1'b0;
    repeat (2) @(negedge TX_CLK_TB);

    $display("[TB] basic frame P=8");
    wave.delete(); pushLevel(1'b1, 2); pushFrame(8'hA5, 1'b0, 1'b1, 0); pushLevel(1'b1, 6);
    applyStimulus("basic", 0);
    checkOutput("basic_strobe_cyc", 0, 12'(strobe_cyc), 12'd82);
    checkOutput("basic_pdata", 0, {4'h0, p_data}, 12'h0A5);

    $display("[TB] parity P=16");
    prescale = 6'd16; par_en = 1'b1; par_typ = 1'b0;
    wave.delete(); pushLevel(1'b1, 2); pushFrame(8'h3C, 1'b0, 1'b1, 0); pushLevel(1'b1, 6);
    applyStimulus("par_even", 0);
    checkOutput("par_even_cyc", 0, 12'(strobe_cyc), 12'd178);
    par_typ = 1'b1;
    wave.delete(); pushLevel(1'b1, 2); pushFrame(8'h3C, 1'b1, 1'b1, 0); pushLevel(1'b1, 6);
    applyStimulus("par_odd", 0);
    checkOutput("par_odd_cyc", 0, 12'(strobe_cyc), 12'd178);
    wave.delete(); pushLevel(1'b1, 2); pushFrame(8'h3C, 1'b0, 1'b1, 0); pushLevel(1'b1, 6);
    applyStimulus("par_bad", 0);
    checkOutput("par_bad_cyc", 0, 12'(strobe_cyc), 12'd178);
    checkOutput("par_bad_hold", 0, {4'h0, p_data}, 12'h03C);

    $display("[TB] stop error and glitch P=32");
    prescale = 6'd32; par_en = 1'b0; par_typ = 1'b0;
    wave.delete(); pushLevel(1'b1, 2); pushFrame(8'h81, 1'b0, 1'b0, 0); pushLevel(1'b1, 6);
    applyStimulus("stop_err", 0);
    checkOutput("stop_err_cyc", 0, 12'(strobe_cyc), 12'd322);
    wave.delete(); pushLevel(1'b1, 2); pushLevel(1'b0, 15); pushLevel(1'b1, 40);
    applyStimulus("glitch", 0);
    checkOutput("glitch_no_strobe", 0, 12'(strobe_cyc), 12'hFFF);

    $display("[TB] noise tolerance P=16");
    prescale = 6'd16;
    wave.delete(); pushLevel(1'b1, 2); pushFrame(8'h5A, 1'b0, 1'b1, 1); pushLevel(1'b1, 6);
    applyStimulus("noise", 0);
    checkOutput("noise_pdata", 0, {4'h0, p_data}, 12'h05A);

    $display("[TB] back-to-back frames");
    wave.delete(); pushLevel(1'b1, 2);
    pushFrame(8'h01, 1'b0, 1'b1, 0); pushFrame(8'hFF, 1'b0, 1'b1, 0); pushFrame(8'h00, 1'b0, 1'b1, 0);
    pushLevel(1'b1, 6);
    applyStimulus("b2b", 0);
    checkOutput("b2b_first_cyc", 0, 12'(strobe_cyc), 12'd162);

    $display("[TB] mid-frame reset");
    wave.delete(); pushLevel(1'b1, 2);
    pushFrame(8'h01, 1'b0, 1'b1, 0); pushFrame(8'hFF, 1'b0, 1'b1, 0); pushLevel(1'b1, 6);
    applyStimulus("pre_reset", 226);
    #2 rst = 1'b1;
    #1 checkOutput("reset_mid", 0, {busy, data_valid, par_err, stp_err, p_data}, 12'h000);
    rx_in = 1'b1;
    repeat (2) @(negedge TX_CLK_TB);
    rst = 1'b0;
    model_pdata = 8'h00;
    wave.delete(); pushLevel(1'b1, 2); pushFrame(8'h96, 1'b0, 1'b1, 0); pushLevel(1'b1, 6);
    applyStimulus("post_reset", 0);
    checkOutput("post_reset_pdata", 0, {4'h0, p_data}, 12'h096);

    $display("[TB] randomized frames");
    for (int r = 0; r < 10; r++) begin
      prescale = PW'(8 << $urandom_range(0, 2));
      par_en   = 1'($urandom_range(0, 1));
      par_typ  = 1'($urandom_range(0, 1));
      wave.delete(); pushLevel(1'b1, 2);
      for (int f = 0; f < 3; f++) begin
        d    = 8'($urandom);
        pbit = (^d) ^ par_typ ^ ($urandom_range(0, 3) == 0);
        pushFrame(d, pbit, ($urandom_range(0, 7) != 0), ($urandom_range(0, 3) == 0));
        pushLevel(1'b1, $urandom_range(0, 3));
      end
      pushLevel(1'b1, 6);
      applyStimulus("random", 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
